// File: rtl/async_mem.sv
// async_mem: single-port RAM with synchronous write and combinational read.
// Reads outside the populated range, and idle reads, return all ones.
module async_mem #(
    parameter int asz   = 8,
    parameter int dsz   = 8,
    parameter int depth = 2**asz
) (
    input  logic           wr_clk,
    input  logic           reset,     // tie low when the clear is not needed
    input  logic [dsz-1:0] wr_data,
    input  logic           wr_cs,
    input  logic [asz-1:0] addr,
    input  logic           rd_cs,
    output logic [dsz-1:0] rd_data
);

    // Index width just wide enough for depth; addr is range-checked first,
    // so truncating it to this width never aliases a valid location.
    localparam int IW = (depth > 1) ? $clog2(depth) : 1;

    // Declaration initializer gives all-zero contents before the first reset.
    logic [dsz-1:0] mem [depth] = '{default: '0};

    logic          in_range;
    logic [IW-1:0] idx;

    assign in_range = (64'(addr) < 64'(depth));
    assign idx      = IW'(addr);

    // Write port: reset clears the whole array in one edge and wins over a
    // write in the same cycle; out-of-range writes are dropped.
    always_ff @(posedge wr_clk) begin
        if (reset) begin
            for (int i = 0; i < depth; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_cs && in_range) begin
            mem[idx] <= wr_data;
        end
    end

    // Read port: zero latency, no write-through bypass; the idle bus value is
    // all ones, as is any read beyond the last word.
    always_comb begin
        rd_data = '1;
        if (rd_cs && in_range) begin
            rd_data = mem[idx];
        end
    end

endmodule

// File: tb/tb_async_mem.sv
// tb_async_mem: directed scoreboard bench for async_mem (depth 127, 8-bit).
module tb_async_mem;

    localparam int ASZ   = 8;
    localparam int DSZ   = 8;
    localparam int DEPTH = 127;

    logic           wr_clk = 1'b0;
    logic           reset  = 1'b0;
    logic [DSZ-1:0] wr_data = '0;
    logic           wr_cs  = 1'b0;
    logic [ASZ-1:0] addr   = '0;
    logic           rd_cs  = 1'b0;
    logic [DSZ-1:0] rd_data;

    int passed = 0;
    int total  = 0;
    logic [DSZ-1:0] sb [$];

    async_mem #(.asz(ASZ), .dsz(DSZ), .depth(DEPTH)) dut (
        .wr_clk  (wr_clk),
        .reset   (reset),
        .wr_data (wr_data),
        .wr_cs   (wr_cs),
        .addr    (addr),
        .rd_cs   (rd_cs),
        .rd_data (rd_data)
    );

    always #5 wr_clk = ~wr_clk;

    // Pop the oldest expectation and compare against the live read port.
    task automatic check(input string tag);
        logic [DSZ-1:0] exp;
        logic [DSZ-1:0] obs;
        exp = sb.pop_front();
        obs = rd_data;
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s addr=%0h observed=%0h expected=%0h", tag, addr, obs, exp);
    endtask

    // Combinational read: drive address/enable, queue expectation, settle, compare.
    task automatic rd(input logic [ASZ-1:0] a, input logic cs,
                      input logic [DSZ-1:0] exp, input string tag);
        addr  = a;
        rd_cs = cs;
        sb.push_back(exp);
        #1;
        check(tag);
    endtask

    // One write on the next rising edge; inputs change on the falling edge.
    task automatic wr(input logic [ASZ-1:0] a, input logic [DSZ-1:0] d);
        @(negedge wr_clk);
        addr    = a;
        wr_data = d;
        wr_cs   = 1'b1;
        @(posedge wr_clk);
        #1;
        wr_cs = 1'b0;
    endtask

    initial begin
        // Power-up contents are zero before any reset
        rd(8'h03, 1'b1, 8'h00, "powerup");

        // Reset pulse then full sweep
        wr(8'h07, 8'hEE);
        @(negedge wr_clk); reset = 1'b1;
        @(negedge wr_clk); reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) rd(ASZ'(i), 1'b1, 8'h00, "reset_sweep");

        // Consecutive writes, read back with no extra cycle
        wr(8'h00, 8'hA5);
        wr(8'h7E, 8'h3C);
        wr(8'h40, 8'h5A);
        rd(8'h00, 1'b1, 8'hA5, "rb_00");
        rd(8'h7E, 1'b1, 8'h3C, "rb_7e_last");
        rd(8'h40, 1'b1, 8'h5A, "rb_40");

        // Out-of-range and idle
        wr(8'h7F, 8'h77);
        rd(8'h7F, 1'b1, 8'hFF, "oor_7f");
        rd(8'hFF, 1'b1, 8'hFF, "oor_ff");
        rd(8'h00, 1'b0, 8'hFF, "idle_00");
        rd(8'h7E, 1'b0, 8'hFF, "idle_7e");
        rd(8'h7E, 1'b1, 8'h3C, "oor_no_alias");
        rd(8'h00, 1'b1, 8'hA5, "oor_no_wrap");

        // Same-cycle read/write: old value before the edge, new after
        wr(8'h10, 8'h11);
        @(negedge wr_clk);
        addr = 8'h10; rd_cs = 1'b1; wr_data = 8'h22; wr_cs = 1'b1;
        sb.push_back(8'h11);
        #1; check("rw_before");
        @(posedge wr_clk); #1;
        wr_cs = 1'b0;
        sb.push_back(8'h22);
        check("rw_after");

        // Reset collides with a write: reset wins, whole array cleared
        @(negedge wr_clk);
        reset = 1'b1; wr_cs = 1'b1; addr = 8'h05; wr_data = 8'h99;
        @(posedge wr_clk); #1;
        reset = 1'b0; wr_cs = 1'b0;
        rd(8'h05, 1'b1, 8'h00, "collide_05");
        for (int i = 0; i < DEPTH; i++) rd(ASZ'(i), 1'b1, 8'h00, "collide_sweep");

        // Enable isolation: wr_data toggles with wr_cs low
        wr(8'h20, 8'h5A);
        wr(8'h7E, 8'hC3);
        for (int i = 0; i < 10; i++) begin
            @(negedge wr_clk);
            addr = 8'h20; wr_data = (i % 2 == 0) ? 8'hFF : 8'h00; wr_cs = 1'b0;
            @(posedge wr_clk); #1;
            rd(8'h20, 1'b1, 8'h5A, "no_wr_cs");
        end
        rd(8'h7E, 1'b1, 8'hC3, "last_word");

        // Writes land regardless of rd_cs
        for (int i = 0; i < 8; i++) begin
            @(negedge wr_clk);
            addr = ASZ'(8'h30 + i); wr_data = DSZ'(8'h81 + i); wr_cs = 1'b1;
            rd_cs = i[0];
            @(posedge wr_clk); #1;
            wr_cs = 1'b0;
        end
        for (int i = 0; i < 8; i++) rd(ASZ'(8'h30 + i), 1'b1, DSZ'(8'h81 + i), "rd_cs_isol");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule
